// File: rtl/ram_ecc_dec.sv
// ram_ecc_dec: read-side SECDED decoder for the Hamming-protected RAM, with saturating error counters.
// Define HAM_SCRUB_EN to add a write-back port that scrubs corrected single-bit errors in place.
module ram_ecc_dec #(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 4,
  parameter  int CNT_W  = 8,
  // smallest P with 2^P >= DATA_W + P + 1
  localparam int PAR_W  = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              sec_err,
  output logic              ded_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CODE_W-1:0] mem_rdata,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
`ifdef HAM_SCRUB_EN
  ,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic [CODE_W-1:0] scrub_wdata
`endif
);

  localparam logic [PAR_W-1:0] LAST_POS = PAR_W'(CODE_W - 1);

  // Hamming position holding data bit k: k-th non-power-of-two index from 3 upward.
  function automatic int data_pos(input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == k) pos = i;
        n++;
      end
    end
    return pos;
  endfunction

  logic              w_rd_ready;
  logic              w_accept;
  logic [PAR_W-1:0]  w_syn;
  logic              w_par;
  logic              w_flip;
  logic              w_sec;
  logic              w_ded;
  logic [DATA_W-1:0] w_data;

  logic              r_inflight;
  logic              r_rd_valid;
  logic              r_sec_err;
  logic              r_ded_err;
  logic [DATA_W-1:0] r_rd_data;
  logic [CNT_W-1:0]  r_sec_cnt;
  logic [CNT_W-1:0]  r_ded_cnt;

  assign w_accept  = rd_req && w_rd_ready;
  assign mem_rd_en = w_accept;
  assign mem_addr  = rd_addr;
  assign rd_ready  = w_rd_ready;

  always_comb begin
    w_syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (mem_rdata[i]) w_syn = w_syn ^ PAR_W'(i);
    end
  end

  assign w_par  = ^mem_rdata;
  assign w_flip = w_par && (w_syn != '0) && (w_syn <= LAST_POS);
  assign w_sec  = w_par && (w_flip || (w_syn == '0));
  assign w_ded  = (w_syn != '0) && !w_flip;

  // Uncorrectable words pass through raw because w_flip is low for them.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < DATA_W; k++) begin
      w_data[k] = mem_rdata[PAR_W'(data_pos(k))] ^ (w_flip && (w_syn == PAR_W'(data_pos(k))));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_rd_valid <= 1'b0;
      r_sec_err  <= 1'b0;
      r_ded_err  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_inflight <= w_accept;
      r_rd_valid <= r_inflight;
      r_sec_err  <= r_inflight && w_sec;
      r_ded_err  <= r_inflight && w_ded;
      if (r_inflight) r_rd_data <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else begin
      if (r_sec_err && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + CNT_W'(1);
      if (r_ded_err && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + CNT_W'(1);
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign sec_err  = r_sec_err;
  assign ded_err  = r_ded_err;
  assign sec_cnt  = r_sec_cnt;
  assign ded_cnt  = r_ded_cnt;

`ifdef HAM_SCRUB_EN
  typedef enum logic {S_IDLE, S_SCRUB} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_scrub_we;
  logic [ADDR_W-1:0] r_scrub_addr;
  logic [CODE_W-1:0] r_scrub_wdata;
  logic [CODE_W-1:0] w_fixed;

  always_comb begin
    w_fixed = mem_rdata;
    if (w_flip) w_fixed[w_syn] = ~mem_rdata[w_syn];
    w_fixed[0] = ^w_fixed[CODE_W-1:1];
  end

  // A correction decoded while already scrubbing simply reloads the scrub
  // registers, so every corrected read gets its write-back in its output cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_scrub_we    <= 1'b0;
      r_scrub_addr  <= '0;
      r_scrub_wdata <= '0;
    end else begin
      if (w_accept) r_addr <= rd_addr;
      case (r_state)
        S_IDLE, S_SCRUB: begin
          if (r_inflight && w_flip) begin
            r_state       <= S_SCRUB;
            r_scrub_we    <= 1'b1;
            r_scrub_addr  <= r_addr;
            r_scrub_wdata <= w_fixed;
          end else begin
            r_state    <= S_IDLE;
            r_scrub_we <= 1'b0;
          end
        end
      endcase
    end
  end

  assign w_rd_ready  = (r_state == S_IDLE);
  assign scrub_we    = r_scrub_we;
  assign scrub_addr  = r_scrub_addr;
  assign scrub_wdata = r_scrub_wdata;
`else
  assign w_rd_ready = 1'b1;
`endif

endmodule
